// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display. Define
// LEADING_ZERO_BLANK_EN to keep leading zero digits dark. Digit 0 is always lit.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 2,
  parameter int SHOW_CYCLES  = 20000,
  parameter int BLANK_CYCLES = 100,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              select,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    pending
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t                         state, state_nx;
  logic [CNT_W-1:0]               cnt;
  logic [NUM_DIGITS-1:0][3:0]     display, staging, disp_nx;
  logic [IDX_W-1:0]               idx_nx;
  logic [NUM_DIGITS-1:0]          anode_nx;
  logic [NUM_DIGITS-1:0]          lz_dark;
  logic                           apply;
  logic                           accept;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    idx_nx   = digit_idx;
    if (state == BLANK && cnt == BLANK_LAST) begin
      state_nx = SHOW;
    end else if (state == SHOW && cnt == SHOW_LAST) begin
      state_nx = BLANK;
      idx_nx   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end

    apply   = (state == BLANK) && pending;
    accept  = load_valid && load_ready;
    disp_nx = apply ? staging : display;
  end

  // A digit is dark when it is zero and so is every higher-index digit.
  // Digit 0 is never dark.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    lz_dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero    = hi_zero && (disp_nx[i] == 4'h0);
      lz_dark[i] = hi_zero;
    end
  end
`else
  always_comb begin
    lz_dark = '0;
  end
`endif

  always_comb begin
    anode_nx = '1;
    if (state_nx == SHOW && !lz_dark[idx_nx]) anode_nx[idx_nx] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  // NOTE: the display and staging registers are reset too: after reset the
  // display must read all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      anode_n    <= '1;
      select     <= 4'h0;
      display    <= '0;
      staging    <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= (state_nx != state) ? '0 : cnt + 1'b1;
      digit_idx <= idx_nx;
      anode_n   <= anode_nx;
      display   <= disp_nx;
      // The code follows the scheduled digit, so it is stable through the blank.
      select    <= disp_nx[idx_nx];
      if (apply) begin
        pending    <= 1'b0;
        load_ready <= 1'b1;
      end else if (accept) begin
        staging    <= digits_in;
        pending    <= 1'b1;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=2, SHOW_CYCLES=4 and BLANK_CYCLES=2.
// "Cycle k" is sampled on the falling edge just before rising edge k, where edge 0 is the first rising edge after reset.
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] digits_in;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] select;
  logic [1:0] anode_n;
  logic       digit_idx;
  logic       pending;

  int vectors;
  int miscompares;

  display_scan_ctrl #(
    .NUM_DIGITS  (2),
    .SHOW_CYCLES (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .select    (select),
    .anode_n   (anode_n),
    .digit_idx (digit_idx),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected scan pattern for a display with every digit lit.
  function automatic logic [1:0] exp_anode(int k);
    int c;
    c = k % 12;
    if (c < 2) return 2'b11;
    if (c < 6) return 2'b10;
    if (c < 8) return 2'b11;
    return 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two cycles, then release it on a falling edge. This leaves the bench at cycle 0.
  task automatic do_reset();
    load_valid = 1'b0;
    digits_in  = 8'h00;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    load_valid = 1'b0;
    digits_in  = 8'h00;
    reset      = 1'b1;
    #3;
    vectors++;
    if (anode_n !== 2'b11 || select !== 4'h0 || digit_idx !== 1'b0 ||
        pending !== 1'b0 || load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got anode_n=%b select=%h idx=%b pending=%b ready=%b want 11 0 0 0 1",
               anode_n, select, digit_idx, pending, load_ready);
    end
    do_reset();
  endtask

  task automatic test_scan();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      vectors++;
      if (anode_n !== exp_anode(k) || select !== 4'h0 ||
          digit_idx !== ((k % 12) >= 6)) begin
        miscompares++;
        $display("FAIL scan cycle %0d: got anode_n=%b select=%h idx=%b want anode_n=%b select=0 idx=%0d",
                 k, anode_n, select, digit_idx, exp_anode(k), int'((k % 12) >= 6));
      end
      step();
    end
  endtask

  task automatic test_load_blank();
    do_reset();
    load_valid = 1'b1;
    digits_in  = 8'h3A;
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_blank ready c0: got %b want 1", load_ready);
    end
    step();
    load_valid = 1'b0;
    digits_in  = 8'h00;
    vectors++;
    if (pending !== 1'b1 || load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_blank pending c1: got pending=%b ready=%b want 1 0", pending, load_ready);
    end
    step();
    for (int k = 2; k < 12; k++) begin
      vectors++;
      if (pending !== 1'b0 || anode_n !== exp_anode(k) ||
          select !== ((k < 6) ? 4'hA : 4'h3)) begin
        miscompares++;
        $display("FAIL load_blank cycle %0d: got pending=%b anode_n=%b select=%h want 0 %b %h",
                 k, pending, anode_n, select, exp_anode(k), (k < 6) ? 4'hA : 4'h3);
      end
      step();
    end
  endtask

  task automatic test_load_show();
    logic [3:0] want;
    do_reset();
    repeat (3) step();
    load_valid = 1'b1;
    digits_in  = 8'h5C;
    step();
    load_valid = 1'b0;
    digits_in  = 8'h00;
    for (int k = 4; k < 14; k++) begin
      want = (k < 7) ? 4'h0 : ((k < 12) ? 4'h5 : 4'hC);
      vectors++;
      if (select !== want || pending !== (k < 7) || anode_n !== exp_anode(k)) begin
        miscompares++;
        $display("FAIL load_show cycle %0d: got select=%h pending=%b anode_n=%b want %h %0d %b",
                 k, select, pending, anode_n, want, int'(k < 7), exp_anode(k));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    do_reset();
    repeat (2) step();
    load_valid = 1'b1;
    digits_in  = 8'h12;
    step();
    // Hold a new offer while the first load is still pending.
    digits_in = 8'hFF;
    for (int k = 3; k < 7; k++) begin
      vectors++;
      if (load_ready !== 1'b0 || pending !== 1'b1 || select !== 4'h0) begin
        miscompares++;
        $display("FAIL b2b blocked cycle %0d: got ready=%b pending=%b select=%h want 0 1 0",
                 k, load_ready, pending, select);
      end
      step();
    end
    digits_in = 8'h9E;
    vectors++;
    if (load_ready !== 1'b1 || pending !== 1'b0 || select !== 4'h1) begin
      miscompares++;
      $display("FAIL b2b applied c7: got ready=%b pending=%b select=%h want 1 0 1",
               load_ready, pending, select);
    end
    step();
    load_valid = 1'b0;
    digits_in  = 8'h00;
    for (int k = 8; k < 18; k++) begin
      want = (k < 12) ? 4'h1 : ((k == 12) ? 4'h2 : 4'hE);
      vectors++;
      if (select !== want || pending !== (k < 13) || anode_n !== exp_anode(k)) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: got select=%h pending=%b anode_n=%b want %h %0d %b",
                 k, select, pending, anode_n, want, int'(k < 13), exp_anode(k));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_valid = 1'b1;
    digits_in  = 8'h3A;
    step();
    load_valid = 1'b0;
    repeat (2) step();
    load_valid = 1'b1;
    digits_in  = 8'h77;
    step();
    load_valid = 1'b0;
    vectors++;
    if (anode_n !== 2'b10 || pending !== 1'b1 || select !== 4'hA) begin
      miscompares++;
      $display("FAIL reset_mid pre c4: got anode_n=%b pending=%b select=%h want 10 1 a",
               anode_n, pending, select);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (anode_n !== 2'b11 || pending !== 1'b0 || digit_idx !== 1'b0 ||
        select !== 4'h0 || load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid async: got anode_n=%b pending=%b idx=%b select=%h ready=%b want 11 0 0 0 1",
               anode_n, pending, digit_idx, select, load_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (anode_n !== exp_anode(k) || select !== 4'h0 || pending !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid restart cycle %0d: got anode_n=%b select=%h pending=%b want %b 0 0",
                 k, anode_n, select, pending, exp_anode(k));
      end
      step();
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [7:0] vals [2];
    logic [1:0] want_an;
    vals[0] = 8'h07;
    vals[1] = 8'h00;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      load_valid = 1'b1;
      digits_in  = vals[v];
      step();
      load_valid = 1'b0;
      digits_in  = 8'h00;
      for (int k = 1; k < 12; k++) begin
        want_an = (exp_anode(k) == 2'b01) ? 2'b11 : exp_anode(k);
        vectors++;
        if (anode_n !== want_an || (k >= 2 && k < 6 && select !== vals[v][3:0])) begin
          miscompares++;
          $display("FAIL leading_zero %h cycle %0d: got anode_n=%b select=%h want %b %h",
                   vals[v], k, anode_n, select, want_an, vals[v][3:0]);
        end
        step();
      end
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load_valid  = 1'b0;
    digits_in   = 8'h00;
    test_reset();
    test_scan();
    test_load_blank();
    test_load_show();
    test_back_to_back();
    test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
